// File: rtl/telem_word_serializer.sv
// Packet FIFO plus word serializer: wide telemetry packets in, gap-free bus words out under full/valid backpressure.
// Optional per-packet header word (sync + sequence) enabled by defining SERIALIZER_HEADER_EN.
module telem_word_serializer #(
  parameter int          PKT_W     = 88,
  parameter int          WORD_W    = 16,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] IDLE_WORD = 16'h00BC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PKT_W-1:0]          pkt_data,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  output logic [WORD_W-1:0]         word_data,
  output logic [WORD_W/8-1:0]       word_be,
  output logic                      word_valid,
  input  logic                      word_full,
  input  logic                      clr_drops,
  output logic [15:0]               drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);
  localparam int N  = (PKT_W + WORD_W - 1) / WORD_W;
  localparam int PW = N * WORD_W;
  localparam int BW = WORD_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef SERIALIZER_HEADER_EN
  localparam int NW = N + 1;
`else
  localparam int NW = N;
`endif
  localparam int CW = $clog2(NW) + 1;
  localparam int LAST_BYTES = (PKT_W - (N - 1) * WORD_W) / 8;
  localparam logic [BW-1:0]     FULL_BE  = '1;
  localparam logic [BW-1:0]     LAST_BE  = BW'((1 << LAST_BYTES) - 1);
  localparam logic [WORD_W-1:0] IDLE_VAL = WORD_W'(IDLE_WORD);

  // state | meaning
  // IDLE  | nothing to send, word_valid low
  // LOAD  | pop FIFO head into shift register, present first word
  // SEND  | present words in order, advance on each transfer
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t            state, state_nxt;
  logic [PKT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic              fifo_empty, fifo_full, push, pop, drop, load;
  logic [PW-1:0]     head_pad, shreg, sh_nxt;
  logic [CW-1:0]     idx, idx_nxt;
  logic [WORD_W-1:0] data_nxt;
  logic [BW-1:0]     be_nxt;
  logic              valid_nxt;
`ifdef SERIALIZER_HEADER_EN
  logic [7:0]        seq;
`endif

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(DEPTH));
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign push       = pkt_valid & (~fifo_full | pop);
  assign drop       = pkt_valid & fifo_full & ~pop;
  assign head_pad   = PW'(mem[rd_ptr]);

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)
      level_nxt = fifo_level + 1'b1;
    else if (pop && !push)
      level_nxt = fifo_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= pkt_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pkt_ready  <= 1'b1;
      drop_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_nxt;
      pkt_ready  <= (level_nxt != LW'(DEPTH));
      if (clr_drops)
        drop_count <= '0;
      else if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sh_nxt    = shreg;
    data_nxt  = word_data;
    be_nxt    = word_be;
    valid_nxt = word_valid;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = LOAD;
      LOAD: load = 1'b1;
      SEND: begin
        if (word_valid && !word_full) begin
          if (idx == CW'(NW - 1)) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
              valid_nxt = 1'b0;
              data_nxt  = IDLE_VAL;
              be_nxt    = '0;
              idx_nxt   = '0;
            end
          end else begin
            idx_nxt  = idx + 1'b1;
            data_nxt = shreg[WORD_W-1:0];
            sh_nxt   = shreg >> WORD_W;
            be_nxt   = (idx_nxt == CW'(NW - 1)) ? LAST_BE : FULL_BE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // loading from SEND on the last transfer keeps the word stream bubble-free
    if (load) begin
      pop       = 1'b1;
      state_nxt = SEND;
      valid_nxt = 1'b1;
      idx_nxt   = '0;
`ifdef SERIALIZER_HEADER_EN
      data_nxt  = WORD_W'({seq, 8'hA5});
      be_nxt    = FULL_BE;
      sh_nxt    = head_pad;
`else
      data_nxt  = head_pad[WORD_W-1:0];
      be_nxt    = (NW == 1) ? LAST_BE : FULL_BE;
      sh_nxt    = head_pad >> WORD_W;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      word_data  <= IDLE_VAL;
      word_be    <= '0;
      word_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      shreg      <= sh_nxt;
      word_data  <= data_nxt;
      word_be    <= be_nxt;
      word_valid <= valid_nxt;
    end
  end

`ifdef SERIALIZER_HEADER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seq <= '0;
    else if (load)
      seq <= seq + 8'd1;
  end
`endif

endmodule

// File: tb/tb_telem_word_serializer.sv
// Scoreboard bench for telem_word_serializer: driver pushes expected words, negedge monitor pops and compares.
module tb_telem_word_serializer;
  localparam int PKT_W  = 88;
  localparam int WORD_W = 16;
  localparam int DEPTH  = 4;
  localparam int N      = (PKT_W + WORD_W - 1) / WORD_W;
  localparam int BW     = WORD_W / 8;
`ifdef SERIALIZER_HEADER_EN
  localparam int NW = N + 1;
`else
  localparam int NW = N;
`endif

  logic              clk, rst_n;
  logic [PKT_W-1:0]  pkt_data;
  logic              pkt_valid, pkt_ready;
  logic [WORD_W-1:0] word_data;
  logic [BW-1:0]     word_be;
  logic              word_valid, word_full, clr_drops;
  logic [15:0]       drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  telem_word_serializer #(.PKT_W(PKT_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .IDLE_WORD(16'h00BC)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .word_data(word_data), .word_be(word_be), .word_valid(word_valid), .word_full(word_full),
    .clr_drops(clr_drops), .drop_count(drop_count), .fifo_level(fifo_level));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WORD_W-1:0] exp_d[$];
  logic [BW-1:0]     exp_be[$];
  int mon_idx = 0;
  int pushed = 0;
  int done_pkts = 0;
  logic [7:0] model_seq = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: header (optional) then payload split into WORD_W slices, zero padded, bytes enabled below PKT_W
  task automatic expect_pkt(input logic [PKT_W-1:0] d);
    logic [WORD_W-1:0] w;
    logic [BW-1:0]     be;
`ifdef SERIALIZER_HEADER_EN
    w = WORD_W'({model_seq, 8'hA5});
    exp_d.push_back(w);
    exp_be.push_back('1);
    model_seq = model_seq + 8'd1;
`endif
    for (int i = 0; i < N; i++) begin
      w  = '0;
      be = '0;
      for (int b = 0; b < WORD_W; b++)
        if (i * WORD_W + b < PKT_W) w[b] = d[i * WORD_W + b];
      for (int j = 0; j < BW; j++)
        be[j] = (i * WORD_W + j * 8 < PKT_W);
      exp_d.push_back(w);
      exp_be.push_back(be);
    end
    pushed++;
  endtask

  task automatic send(input logic [PKT_W-1:0] d, input bit accept);
    pkt_data  = d;
    pkt_valid = 1'b1;
    if (accept) expect_pkt(d);
    step();
    pkt_valid = 1'b0;
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    return PKT_W'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_d.size() != 0 || word_valid) && c < budget) begin
      step();
      c++;
    end
    check("drain_timeout", (c < budget), 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_idx = 0;
      exp_d.delete();
      exp_be.delete();
    end else if (word_valid) begin
      if (exp_d.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: actual %0h required none at %0t", word_data, $time);
      end else begin
        check("word_data", word_data, exp_d[0]);
        check("word_be", word_be, exp_be[0]);
        if (!word_full) begin
          void'(exp_d.pop_front());
          void'(exp_be.pop_front());
          if (mon_idx == NW - 1) begin
            mon_idx = 0;
            done_pkts++;
          end else begin
            mon_idx++;
          end
        end
      end
    end else begin
      check("idle_data", word_data, 16'h00BC);
      check("idle_be", word_be, 0);
      check("valid_mid_packet", mon_idx, 0);
    end
  end

  initial begin
    int c, run, rises, maxlvl;
    logic prev;
    logic [WORD_W-1:0] held;
    rst_n = 1'b0; pkt_valid = 1'b0; pkt_data = '0; word_full = 1'b0; clr_drops = 1'b0;
    #12;
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 16'h00BC);
    check("rst_be", word_be, 0);
    check("rst_ready", pkt_ready, 1);
    check("rst_drops", drop_count, 0);
    check("rst_level", fifo_level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // single packet latency
    send(88'h0B0A_0908_0706_0504_0302_01, 1);
    check("lat_k", word_valid, 0);
    step();
    check("lat_k1", word_valid, 0);
    step();
    check("lat_k2_valid", word_valid, 1);
`ifdef SERIALIZER_HEADER_EN
    check("lat_k2_data", word_data, 16'h00A5);
`else
    check("lat_k2_data", word_data, 16'h0201);
`endif
    check("lat_k2_be", word_be, 2'b11);
    wait_drain(50);
    check("after_valid", word_valid, 0);
    check("after_data", word_data, 16'h00BC);

    // three back-to-back packets: one contiguous burst
    maxlvl = 0;
    for (int p = 0; p < 3; p++) begin
      send(rnd_pkt(), 1);
      if (fifo_level > maxlvl) maxlvl = fifo_level;
    end
    run = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 3 * NW + 10; i++) begin
      if (fifo_level > maxlvl) maxlvl = fifo_level;
      if (word_valid) run++;
      if (word_valid && !prev) rises++;
      prev = word_valid;
      step();
    end
    check("burst_words", run, 3 * NW);
    check("burst_rises", rises, 1);
    check("burst_peak_level", maxlvl, 2);
    wait_drain(50);

    // backpressure on word 2
    send(rnd_pkt(), 1);
    c = 0;
    while (!(word_valid && mon_idx == 2) && c < 50) begin step(); c++; end
    check("bp_reach_word2", (c < 50), 1);
    word_full = 1'b1;
    held = word_data;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_data", word_data, held);
      check("bp_hold_valid", word_valid, 1);
    end
    word_full = 1'b0;
    wait_drain(50);

    // randomized traffic, kept below drop threshold
    for (int i = 0; i < 400; i++) begin
      word_full = ($urandom_range(0, 3) == 0);
      if ((pushed - done_pkts) < DEPTH && $urandom_range(0, 1) == 0)
        send(rnd_pkt(), 1);
      else
        step();
    end
    word_full = 1'b0;
    wait_drain(400);
    check("rand_drops", drop_count, 0);

    // overflow with permanent full: p1 in flight, p2..p5 in FIFO, p6/p7 dropped
    word_full = 1'b1;
    for (int p = 0; p < 5; p++) send(rnd_pkt(), 1);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_ready", pkt_ready, 0);
    send(rnd_pkt(), 0);
    check("ovf_drop1", drop_count, 1);
    send(rnd_pkt(), 0);
    check("ovf_drop2", drop_count, 2);
    check("ovf_level2", fifo_level, DEPTH);
    clr_drops = 1'b1;
    step();
    clr_drops = 1'b0;
    check("clr_drops", drop_count, 0);
    clr_drops = 1'b1;
    send(rnd_pkt(), 0);
    clr_drops = 1'b0;
    check("clr_with_drop", drop_count, 0);
    // release full; push lands exactly on the edge that pops at full
    word_full = 1'b0;
    repeat (NW - 1) step();
    send(rnd_pkt(), 1);
    check("pushpop_level", fifo_level, DEPTH);
    check("pushpop_drops", drop_count, 0);
    wait_drain(300);

    // reset during word 3
    send(rnd_pkt(), 1);
    c = 0;
    while (!(word_valid && mon_idx == 3) && c < 50) begin step(); c++; end
    check("rst_reach_word3", (c < 50), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", word_valid, 0);
    check("arst_data", word_data, 16'h00BC);
    check("arst_be", word_be, 0);
    check("arst_ready", pkt_ready, 1);
    check("arst_level", fifo_level, 0);
    model_seq = 8'd0;
    step();
    step();
    pushed = 0;
    done_pkts = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_quiet", word_valid, 0);
    end

    // sustained one packet per NW cycles is lossless (257 packets covers sequence wrap)
    for (int p = 0; p < 257; p++) begin
      send(rnd_pkt(), 1);
      repeat (NW - 1) step();
    end
    wait_drain(200);
    check("sustained_drops", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
